rvsteel_input_debouncer: RTL and testbench

//   Conditions NUM_INPUTS asynchronous board pins (buttons, switches) for use in the SoC clock domain.

---
 rtl/rvsteel_input_debouncer.sv | 104 ++++++++++
 tb/tb_rvsteel_input_debouncer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_input_debouncer.sv
// -----------------------------------------------------------------------------
// rvsteel_input_debouncer
//
// Conditions NUM_INPUTS asynchronous board pins (buttons, switches) for use in
// the SoC clock domain. Each channel is fully independent and consists of:
//   - a 2-flop synchroniser,
//   - optional polarity inversion (ACTIVE_LOW),
//   - a counter-based debounce filter that accepts a new level only after the
//     synchronised value has differed from the accepted value for
//     DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clock       in   1           system clock, all logic on posedge
//   reset       in   1           synchronous, active-high
//   raw_input   in   NUM_INPUTS  asynchronous pin levels
//   debounced   out  NUM_INPUTS  filtered logical level per channel
//   rise_pulse  out  NUM_INPUTS  1-cycle pulse when debounced goes 0->1
//   fall_pulse  out  NUM_INPUTS  1-cycle pulse when debounced goes 1->0
//   busy        out  1           high while any synced level != debounced
// -----------------------------------------------------------------------------
module rvsteel_input_debouncer #(
    parameter int NUM_INPUTS      = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 0,
    parameter int RESET_VALUE     = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] raw_input,
    output logic [NUM_INPUTS-1:0] debounced,
    output logic [NUM_INPUTS-1:0] rise_pulse,
    output logic [NUM_INPUTS-1:0] fall_pulse,
    output logic                  busy
);

    localparam int                    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic                  INV_BIT  = (ACTIVE_LOW != 0);
    localparam logic                  RST_BIT  = (RESET_VALUE != 0);
    localparam logic [NUM_INPUTS-1:0] INV_MASK = {NUM_INPUTS{INV_BIT}};
    localparam logic [NUM_INPUTS-1:0] DEB_RST  = {NUM_INPUTS{RST_BIT}};
    // Sync flops hold the physical pin level, so their reset value is the
    // logical reset value pushed back through the polarity inversion. This
    // keeps synced == debounced right after reset (busy = 0).
    localparam logic [NUM_INPUTS-1:0] SYNC_RST = DEB_RST ^ INV_MASK;

    logic [NUM_INPUTS-1:0] r_ff1;
    logic [NUM_INPUTS-1:0] r_ff2;
    logic [NUM_INPUTS-1:0] w_synced;
    logic [NUM_INPUTS-1:0] r_debounced;
    logic [NUM_INPUTS-1:0] r_rise;
    logic [NUM_INPUTS-1:0] r_fall;
    logic [CNT_W-1:0]      r_count [NUM_INPUTS];

    // Two-flop synchroniser on the raw pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ff1 <= SYNC_RST;
            r_ff2 <= SYNC_RST;
        end else begin
            r_ff1 <= raw_input;
            r_ff2 <= r_ff1;
        end
    end

    assign w_synced = r_ff2 ^ INV_MASK;

    // Debounce filter. The counter restarts whenever the synced level returns
    // to the accepted level, so only an uninterrupted run is accepted. It is
    // cleared on acceptance and therefore never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_count[i] <= '0;
            end
            r_debounced <= DEB_RST;
            r_rise      <= '0;
            r_fall      <= '0;
        end else begin
            r_rise <= '0;
            r_fall <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (w_synced[i] == r_debounced[i]) begin
                    r_count[i] <= '0;
                end else if (r_count[i] == CNT_LAST) begin
                    r_debounced[i] <= w_synced[i];
                    r_count[i]     <= '0;
                    // Pulses register on the same edge as the level update.
                    r_rise[i]      <= w_synced[i];
                    r_fall[i]      <= ~w_synced[i];
                end else begin
                    r_count[i] <= r_count[i] + CNT_W'(1);
                end
            end
        end
    end

    assign debounced  = r_debounced;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    // Built only from registered terms: no path from raw_input to busy.
    assign busy       = |(w_synced ^ r_debounced);

endmodule

// File: tb/tb_rvsteel_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_rvsteel_input_debouncer
//
// Directed bench for rvsteel_input_debouncer. Main instance: NUM_INPUTS=2,
// DEBOUNCE_CYCLES=4, ACTIVE_LOW=0, RESET_VALUE=0. A second instance with
// ACTIVE_LOW=1 shares clock and reset.
// Edge numbering: edge 0 is the first posedge that sees a new raw value
// (or the first non-reset edge). Outputs are sampled 1 time unit after edges.
// -----------------------------------------------------------------------------
module tb_rvsteel_input_debouncer;

    logic       clk;
    logic       rst;
    logic [1:0] raw;
    logic [1:0] deb;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       busy;

    logic [1:0] raw2;
    logic [1:0] deb2;
    logic [1:0] rise2;
    logic [1:0] fall2;
    logic       busy2;

    int total;
    int bad;

    rvsteel_input_debouncer #(
        .NUM_INPUTS     (2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (0),
        .RESET_VALUE    (0)
    ) u_dut (
        .clock     (clk),
        .reset     (rst),
        .raw_input (raw),
        .debounced (deb),
        .rise_pulse(rise),
        .fall_pulse(fall),
        .busy      (busy)
    );

    rvsteel_input_debouncer #(
        .NUM_INPUTS     (2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (1),
        .RESET_VALUE    (0)
    ) u_dut_al (
        .clock     (clk),
        .reset     (rst),
        .raw_input (raw2),
        .debounced (deb2),
        .rise_pulse(rise2),
        .fall_pulse(fall2),
        .busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw = 2'b00;
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if ({deb, rise, fall, busy} !== 7'b0) begin
                bad++;
                $display("FAIL reset_hold n=%0d got deb=%b rise=%b fall=%b busy=%b exp all 0",
                         n, deb, rise, fall, busy);
            end
        end
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            total++;
            if ({deb, rise, fall, busy} !== 7'b0) begin
                bad++;
                $display("FAIL reset_idle n=%0d got deb=%b rise=%b fall=%b busy=%b exp all 0",
                         n, deb, rise, fall, busy);
            end
        end
    endtask

    task automatic test_bounce();
        bit seen_hi;
        bit seen_lo;
        seen_hi = 1'b0;
        seen_lo = 1'b0;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 4; k++) begin
                raw = (k < 3) ? 2'b01 : 2'b00;
                tick();
                if (busy === 1'b1) seen_hi = 1'b1;
                if (busy === 1'b0) seen_lo = 1'b1;
                total++;
                if ({deb, rise, fall} !== 6'b0) begin
                    bad++;
                    $display("FAIL bounce r=%0d k=%0d got deb=%b rise=%b fall=%b exp all 0",
                             r, k, deb, rise, fall);
                end
            end
        end
        total++;
        if (!(seen_hi && seen_lo)) begin
            bad++;
            $display("FAIL bounce_busy got seen_hi=%0d seen_lo=%0d exp both 1", seen_hi, seen_lo);
        end
        raw = 2'b00;
        for (int n = 0; n < 4; n++) tick();
        total++;
        if ({deb, busy} !== 3'b0) begin
            bad++;
            $display("FAIL bounce_settle got deb=%b busy=%b exp 00/0", deb, busy);
        end
    endtask

    task automatic test_rise();
        logic [1:0] e_deb;
        logic [1:0] e_rise;
        logic       e_busy;
        raw = 2'b01;
        for (int n = 0; n < 10; n++) begin
            tick();
            e_deb  = (n >= 5) ? 2'b01 : 2'b00;
            e_rise = (n == 5) ? 2'b01 : 2'b00;
            e_busy = (n >= 1 && n <= 4);
            total++;
            if (deb !== e_deb) begin
                bad++;
                $display("FAIL rise_deb n=%0d got=%b exp=%b", n, deb, e_deb);
            end
            total++;
            if (rise !== e_rise || fall !== 2'b00) begin
                bad++;
                $display("FAIL rise_pulse n=%0d got rise=%b fall=%b exp rise=%b fall=00",
                         n, rise, fall, e_rise);
            end
            total++;
            if (busy !== e_busy) begin
                bad++;
                $display("FAIL rise_busy n=%0d got=%b exp=%b", n, busy, e_busy);
            end
        end
    endtask

    task automatic test_both_fall();
        logic [1:0] e_deb;
        logic [1:0] e_fall;
        raw = 2'b11;
        for (int n = 0; n < 10; n++) tick();
        total++;
        if (deb !== 2'b11) begin
            bad++;
            $display("FAIL fall_setup got=%b exp=11", deb);
        end
        raw = 2'b00;
        for (int n = 0; n < 9; n++) begin
            tick();
            e_deb  = (n >= 5) ? 2'b00 : 2'b11;
            e_fall = (n == 5) ? 2'b11 : 2'b00;
            total++;
            if (deb !== e_deb) begin
                bad++;
                $display("FAIL fall_deb n=%0d got=%b exp=%b", n, deb, e_deb);
            end
            total++;
            if (fall !== e_fall || rise !== 2'b00) begin
                bad++;
                $display("FAIL fall_pulse n=%0d got fall=%b rise=%b exp fall=%b rise=00",
                         n, fall, rise, e_fall);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] e_deb;
        logic [1:0] e_rise;
        logic       e_busy;
        raw = 2'b01;
        // Edges 0..3: after edge 3 counter[0] == 2.
        for (int n = 0; n < 4; n++) tick();
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            total++;
            if ({deb, rise, fall, busy} !== 7'b0) begin
                bad++;
                $display("FAIL mid_reset n=%0d got deb=%b rise=%b fall=%b busy=%b exp all 0",
                         n, deb, rise, fall, busy);
            end
        end
        rst = 1'b0;
        for (int n = 0; n < 9; n++) begin
            tick();
            e_deb  = (n >= 5) ? 2'b01 : 2'b00;
            e_rise = (n == 5) ? 2'b01 : 2'b00;
            e_busy = (n >= 1 && n <= 4);
            total++;
            if (deb !== e_deb || rise !== e_rise || fall !== 2'b00) begin
                bad++;
                $display("FAIL mid_after n=%0d got deb=%b rise=%b fall=%b exp deb=%b rise=%b fall=00",
                         n, deb, rise, fall, e_deb, e_rise);
            end
            total++;
            if (busy !== e_busy) begin
                bad++;
                $display("FAIL mid_busy n=%0d got=%b exp=%b", n, busy, e_busy);
            end
        end
        // Reset while debounced[0]=1: no fall pulse may appear.
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            total++;
            if ({deb, rise, fall} !== 6'b0) begin
                bad++;
                $display("FAIL reset_from_one n=%0d got deb=%b rise=%b fall=%b exp all 0",
                         n, deb, rise, fall);
            end
        end
        rst = 1'b0;
        raw = 2'b00;
        for (int n = 0; n < 6; n++) begin
            tick();
            total++;
            if ({deb, rise, fall, busy} !== 7'b0) begin
                bad++;
                $display("FAIL reset_from_one_idle n=%0d got deb=%b rise=%b fall=%b busy=%b exp all 0",
                         n, deb, rise, fall, busy);
            end
        end
    endtask

    task automatic test_active_low();
        logic [1:0] e_deb;
        logic [1:0] e_rise;
        logic       e_busy;
        raw2 = 2'b11;
        rst  = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            total++;
            if ({deb2, rise2, fall2, busy2} !== 7'b0) begin
                bad++;
                $display("FAIL al_reset n=%0d got deb=%b rise=%b fall=%b busy=%b exp all 0",
                         n, deb2, rise2, fall2, busy2);
            end
        end
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            total++;
            if ({deb2, rise2, fall2, busy2} !== 7'b0) begin
                bad++;
                $display("FAIL al_idle n=%0d got deb=%b rise=%b fall=%b busy=%b exp all 0",
                         n, deb2, rise2, fall2, busy2);
            end
        end
        raw2 = 2'b01;
        for (int n = 0; n < 9; n++) begin
            tick();
            e_deb  = (n >= 5) ? 2'b10 : 2'b00;
            e_rise = (n == 5) ? 2'b10 : 2'b00;
            e_busy = (n >= 1 && n <= 4);
            total++;
            if (deb2 !== e_deb || rise2 !== e_rise || fall2 !== 2'b00) begin
                bad++;
                $display("FAIL al_press n=%0d got deb=%b rise=%b fall=%b exp deb=%b rise=%b fall=00",
                         n, deb2, rise2, fall2, e_deb, e_rise);
            end
            total++;
            if (busy2 !== e_busy) begin
                bad++;
                $display("FAIL al_busy n=%0d got=%b exp=%b", n, busy2, e_busy);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        raw   = 2'b00;
        raw2  = 2'b11;
        test_reset();
        test_bounce();
        test_rise();
        test_both_fall();
        test_reset_mid();
        test_active_low();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
